// File: rtl/counter3_monitor.sv
// rtl/counter3_monitor.sv - 3-bit counter behaviour monitor with event FIFO and mismatch counter
// Predicts the next count from the observed commands and queues wrap/set/load/mismatch events.
module counter3_monitor #(
    parameter int DEPTH = 4,
    parameter int ERRW  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set,
    input  logic            load,
    input  logic [2:0]      count,
    input  logic            err_clr,
    input  logic            evt_ready,
    output logic            evt_valid,
    output logic [2:0]      evt_code,
    output logic [2:0]      evt_value,
    output logic            mismatch,
    output logic [ERRW-1:0] err_cnt,
    output logic            overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        EVT_NONE     = 3'd0,
        EVT_WRAP     = 3'd1,
        EVT_SET      = 3'd2,
        EVT_LOAD     = 3'd3,
        EVT_MISMATCH = 3'd4
    } evt_t;

    logic [2:0]  exp_cnt;
    logic [2:0]  shd;
    logic        chk_en;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [5:0]  mem [DEPTH];

    logic        miss;
    logic [2:0]  rot;
    logic [2:0]  exp_next;
    evt_t        code;
    logic        push;
    logic        pop;
    logic        empty;
    logic        full;
    logic        accept;
    logic        drop;

    // The prediction is always rebuilt from the observed count, so a single bad sample
    // costs exactly one mismatch rather than a cascade.
    always_comb begin
        miss     = chk_en && (count != exp_cnt);
        rot      = {count[1:0], count[2]};
        exp_next = count + 3'd1;
        if (set) begin
            exp_next = 3'd7;
        end else if (load) begin
            exp_next = rot;
        end
    end

    always_comb begin
        code = EVT_NONE;
        if (miss) begin
            code = EVT_MISMATCH;
        end else if (set) begin
            code = EVT_SET;
        end else if (load) begin
            code = EVT_LOAD;
        end else if (count == 3'd7) begin
            code = EVT_WRAP;
        end
    end

    // Extra pointer MSB separates full from empty when the index bits match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push   = (code != EVT_NONE);
    assign pop    = !empty && evt_ready;
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    assign evt_valid = !empty;
    assign {evt_code, evt_value} = empty ? 6'd0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_cnt  <= '0;
            shd      <= '0;
            chk_en   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            exp_cnt  <= exp_next;
            chk_en   <= 1'b1;
            mismatch <= miss;
            if (load) begin
                shd <= rot;
            end
            if (accept) begin
                mem[wr_ptr[AW-1:0]] <= {code, count};
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (err_clr) begin
                err_cnt <= miss ? ERRW'(1) : '0;
            end else if (miss && !(&err_cnt)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (err_clr) begin
                overflow <= drop;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
